instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the single-issue core. It owns the PC and issues sequential fetches to instruction memory.
- Fetched words are buffered in a small FIFO and presented to the decode stage with a valid/ready handshake. The decode stage consumes instr_o[6:0] as its opcode.
- Taken branches from the execute stage redirect the PC and flush all buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, instruction FIFO entries (power of 2, 2..16).
- AW, 32, PC and instruction-memory address width.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset: synchronous, active-low.
- imem_req_o  out  1  fetch request this cycle.
- imem_addr_o  out  AW  byte address of the request (word aligned, [1:0]=0).
- imem_rdata_i  in  32  instruction word, valid exactly 1 cycle after an accepted request.
- instr_o  out  32  instruction at FIFO head.
- pc_o  out  AW  PC of instr_o.
- instr_op_o  out  7  instr_o[6:0], for the decoder.
- valid_o  out  1  FIFO head valid.
- ready_i  in  1  decode accepts the head this cycle.
- redirect_i  in  1  branch taken or jump, flush and refetch.
- redirect_pc_i  in  AW  new fetch PC (bits [1:0] ignored and forced to 0).
- count_o  out  $clog2(DEPTH)+1  current FIFO occupancy (debug/perf).

Behaviour:
- Reset, while rst_i=0 at a clock edge:
  - fetch_pc=RESET_PC; FIFO empty (count_o=0).
  - inflight=0; imem_req_o=0; valid_o=0.
  - instr_o=0; pc_o=0; instr_op_o=0.
  - Reset has priority over redirect and handshakes. Asserting reset mid-operation discards everything.
- Memory model: fixed 1-cycle latency, no stall. A request in cycle N returns imem_rdata_i in cycle N+1 and is written into the FIFO at the end of cycle N+1 together with its PC.
- Issue rule:
  - imem_req_o=1 iff rst_i=1, redirect_i=0, and (count + inflight + 1) <= DEPTH after accounting for a pop this cycle. Credits therefore never overflow the FIFO.
  - imem_addr_o=fetch_pc. On issue, fetch_pc += 4, and the issued PC is held in a pipeline register for the returning word.
- Output handshake:
  - valid_o = (count != 0).
  - A pop occurs when valid_o && ready_i. The head is removed at the clock edge and the next entry appears the following cycle.
  - instr_o, pc_o and instr_op_o are stable while valid_o=1 and ready_i=0.
- Throughput and latency:
  - Steady state with ready_i=1 gives 1 instruction per cycle.
  - First valid_o rises 2 cycles after reset deasserts: request in cycle 0, write in cycle 1, valid in cycle 2.
- Simultaneous push and pop: allowed at any count including full (count==DEPTH). Occupancy is unchanged.
- Wrap-around: read and write pointers are modulo DEPTH. fetch_pc wraps modulo 2^AW with no error.
- Redirect, when redirect_i=1 at an edge:
  - FIFO flushed (count=0).
  - Any in-flight response is marked stale and not written in the next cycle.
  - fetch_pc = {redirect_pc_i[AW-1:2],2'b00}.
  - No request is issued in the redirect cycle; the first new request goes out the next cycle.
  - A concurrent pop is ignored (redirect wins); valid_o drops the next cycle.
  - Back-to-back redirects: the last one wins, and each one squashes the previous in-flight request.
- Empty with ready_i=1: no pop and no state change. Full with ready_i=0: imem_req_o=0 until space frees.

Test Plan:
- Reset then free-run, ready_i=1, RESET_PC=0, imem returns word=addr -> valid_o rises cycle 2; pc_o sequence 0,4,8,12… one per cycle; instr_op_o=instr_o[6:0].
- Backpressure: ready_i=0 for 10 cycles after reset -> count_o saturates at 4; imem_req_o=0 while full; instr_o holds the PC=0 word. Releasing ready_i yields PCs 0,4,8,12,16 with no gap or duplicate.
- Redirect to 0x100 while FIFO holds 3 entries and one request is in flight -> next cycle count_o=0, valid_o=0; stale word dropped; imem_addr_o=0x100 one cycle after redirect; first pc_o=0x100.
- Redirect with valid_o=ready_i=1 the same cycle, redirect_pc_i=0x203 -> pop ignored; fetch restarts at 0x200.
- Reset mid-stream (rst_i=0 one cycle with FIFO at 2 entries) -> the next cycle shows all outputs 0, and fetch restarts at RESET_PC.
- Random ready_i toggling over 1000 cycles against a scoreboard -> accepted PCs strictly sequential between redirects; count_o never exceeds DEPTH; no lost or duplicate instructions.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: owns the PC, issues fetches, buffers returned words in a small FIFO.
// Fetched words become valid 2 cycles after issue. Decode stalls via ready_i; issue throttled by FIFO credits.
module instr_fetch_unit #(
  parameter int             AW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int             DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       imem_req_o,
  output logic [AW-1:0]              imem_addr_o,
  input  logic [31:0]                imem_rdata_i,
  output logic [31:0]                instr_o,
  output logic [AW-1:0]              pc_o,
  output logic [6:0]                 instr_op_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  input  logic                       redirect_i,
  input  logic [AW-1:0]              redirect_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t          fifoMem [DEPTH];
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [CW-1:0]   count;
  logic [AW-1:0]   fetchPc;
  logic [AW-1:0]   inflightPc;
  logic            inflight;

  logic            headVld;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     slotsNeeded;

  always_comb begin
    headVld = (count != '0);
    pop     = headVld && ready_i && !redirect_i;
    // A redirect flushes the FIFO at this edge, so the returning word is dropped.
    push    = inflight && !redirect_i;
    // Occupancy after this edge plus the word a new request would bring back.
    slotsNeeded = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight) + (CW+1)'(1);
    issue   = rst_i && !redirect_i && (slotsNeeded <= (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
    end else if (redirect_i) begin
      fetchPc  <= {redirect_pc_i[AW-1:2], 2'b00};
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetchPc    <= fetchPc + AW'(4);
        inflightPc <= fetchPc;
      end
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) fifoMem[wrPtr] <= '{instr: imem_rdata_i, pc: inflightPc};
  end

  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = fetchPc;
    valid_o     = headVld;
    count_o     = count;
    instr_o     = headVld ? fifoMem[rdPtr].instr : '0;
    pc_o        = headVld ? fifoMem[rdPtr].pc    : '0;
    instr_op_o  = instr_o[6:0];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle instruction memory model and a randomised ready phase.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  instr_op_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.AW(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_op_o(instr_op_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  // Instruction memory: answers an accepted request one cycle later.
  always_ff @(posedge clk_i) begin
    if (imem_req_o) imem_rdata_i <= memWord(imem_addr_o);
    else            imem_rdata_i <= 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkHead(input string tag, input logic [31:0] expPc);
    logic [31:0] w;
    w = memWord(expPc);
    chk({tag, "_vld"},   32'(valid_o), 1);
    chk({tag, "_pc"},    pc_o, expPc);
    chk({tag, "_instr"}, instr_o, w);
    chk({tag, "_op"},    32'(instr_op_o), 32'(w[6:0]));
  endtask

  // Leaves the bench in cycle 0 after reset with ready_i=0.
  task automatic doReset();
    rst_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] expPc;
    logic [31:0] tgt;
    int          accepted;

    // Reset state
    rst_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_req",   32'(imem_req_o), 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc",    pc_o, 0);
    chk("rst_op",    32'(instr_op_o), 0);

    // Free run: first valid in cycle 2, then one instruction per cycle
    rst_i = 1'b1; ready_i = 1'b1;
    #1;
    chk("run_c0_req",  32'(imem_req_o), 1);
    chk("run_c0_addr", imem_addr_o, 32'h0);
    @(negedge clk_i); #1;
    chk("run_c1_valid", 32'(valid_o), 0);
    chk("run_c1_addr",  imem_addr_o, 32'h4);
    @(negedge clk_i); #1;
    chkHead("run_c2", 32'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i); #1;
      chkHead("run_seq", 32'(4 * i));
      chk("run_count", 32'(count_o), 1);
    end

    // Backpressure: fills to DEPTH and stops requesting
    doReset();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i); #1;
      chk("bp_count_max", 32'(count_o <= 3'd4), 1);
    end
    chk("bp_count_full", 32'(count_o), 4);
    chk("bp_req_full",   32'(imem_req_o), 0);
    chkHead("bp_hold", 32'h0);
    ready_i = 1'b1; #1;
    chk("bp_rel_req",  32'(imem_req_o), 1);
    chk("bp_rel_addr", imem_addr_o, 32'h10);
    for (int i = 0; i < 6; i++) begin
      chkHead("bp_drain", 32'(4 * i));
      @(negedge clk_i); #1;
    end

    // Redirect with 3 buffered entries and one request in flight
    doReset();
    repeat (4) @(negedge clk_i);
    #1;
    chk("rd_pre_count", 32'(count_o), 3);
    redirect_i = 1'b1; redirect_pc_i = 32'h100; #1;
    chk("rd_cycle_req", 32'(imem_req_o), 0);
    @(negedge clk_i); redirect_i = 1'b0; #1;
    chk("rd_n1_count", 32'(count_o), 0);
    chk("rd_n1_valid", 32'(valid_o), 0);
    chk("rd_n1_req",   32'(imem_req_o), 1);
    chk("rd_n1_addr",  imem_addr_o, 32'h100);
    @(negedge clk_i); #1;
    chk("rd_stale_count", 32'(count_o), 0);
    @(negedge clk_i); #1;
    chkHead("rd_first", 32'h100);
    chk("rd_first_count", 32'(count_o), 1);

    // Redirect wins over a concurrent pop; low address bits dropped
    ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    @(negedge clk_i); redirect_i = 1'b0; #1;
    chk("rdpop_valid", 32'(valid_o), 0);
    chk("rdpop_count", 32'(count_o), 0);
    chk("rdpop_addr",  imem_addr_o, 32'h200);
    repeat (2) @(negedge clk_i);
    #1;
    chkHead("rdpop_first", 32'h200);

    // Back-to-back redirects: last one wins
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    @(negedge clk_i); redirect_pc_i = 32'h400;
    @(negedge clk_i); redirect_i = 1'b0; #1;
    chk("b2b_addr", imem_addr_o, 32'h400);
    repeat (2) @(negedge clk_i);
    #1;
    chkHead("b2b_first", 32'h400);

    // Reset mid-stream with 2 entries buffered
    doReset();
    repeat (3) @(negedge clk_i);
    #1;
    chk("mrst_pre_count", 32'(count_o), 2);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("mrst_count", 32'(count_o), 0);
    chk("mrst_valid", 32'(valid_o), 0);
    chk("mrst_req",   32'(imem_req_o), 0);
    chk("mrst_instr", instr_o, 0);
    chk("mrst_pc",    pc_o, 0);
    chk("mrst_op",    32'(instr_op_o), 0);
    rst_i = 1'b1; ready_i = 1'b1; #1;
    chk("mrst_addr", imem_addr_o, 32'h0);
    repeat (2) @(negedge clk_i);
    #1;
    chkHead("mrst_first", 32'h0);

    // Random ready with occasional redirects; starts near the top of the address space to wrap
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9; expPc = 32'hFFFF_FFF8;
    @(negedge clk_i);
    accepted = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      ready_i    = ($urandom_range(0, 3) != 0);
      redirect_i = ($urandom_range(0, 59) == 0);
      tgt        = $urandom;
      redirect_pc_i = tgt;
      #1;
      chk("rnd_count_max", 32'(count_o <= 3'd4), 1);
      if (valid_o && ready_i && !redirect_i) begin
        chk("rnd_pc", pc_o, expPc);
        chk("rnd_instr", instr_o, memWord(expPc));
        expPc = expPc + 32'h4;
        accepted++;
      end
      if (redirect_i) expPc = {tgt[31:2], 2'b00};
      @(negedge clk_i);
    end
    redirect_i = 1'b0;
    chk("rnd_progress", 32'(accepted > 300), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
